receiver_control: RTL and testbench
===================================

// Module: receiver_control
// PURPOSE
//  Receive-side counterpart of the sender path: accepts 16-bit words over the four-phase
//  Request/Ack handshake, stores them in an internal DEPTH-entry circular buffer, and lets
//  the host pop words out with a read strobe. Applies backpressure by withholding Ack when full.
// PARAMETERS
//  WIDTH   16  data word width
//  DEPTH   16  buffer entries; power of two, >= 2
//  AW       4  pointer width, = log2(DEPTH)
// PORTS
//  clk        in   1        rising-edge clock
//  Reset_n    in   1        asynchronous, active-low reset
//  Request    in   1        sender asserts while rcvDataIn is valid
//  rcvDataIn  in   WIDTH    word from sender; stable while Request=1
//  Ack        out  1        registered handshake acknowledge
//  read       in   1        host pop strobe, one word per cycle high
//  dataOut    out  WIDTH    popped word, registered
//  dataValid  out  1        one-cycle pulse: dataOut updated
//  count      out  AW+1     words stored, 0..DEPTH
//  full       out  1        count == DEPTH
//  empty      out  1        count == 0
//  rdErr      out  1        sticky: read while empty
// BEHAVIOUR
//  Reset (async assert, sync release): Ack=0, dataOut=0, dataValid=0, count=0, rdErr=0,
//   wr_ptr=rd_ptr=0, FSM=IDLE. Memory contents unspecified. Reset mid-handshake drops Ack
//   immediately; the captured-but-unacked word is lost; the sender must restart.
//  req = Request (or its synchronized copy, see CONFIGURATION).
//  Handshake FSM (registered):
//   IDLE: req=1 && !full -> mem[wr_ptr]<=rcvDataIn, wr_ptr<=wr_ptr+1, Ack<=1, go ACK.
//         req=1 && full  -> stay IDLE, Ack=0, no write (backpressure).
//   ACK:  Ack held 1; req=0 -> Ack<=0, go IDLE. req=1 -> stay (no further writes).
//  Latency: req sampled 1 at edge N -> word written and Ack=1 after edge N.
//   req sampled 0 at edge M in ACK -> Ack=0 after edge M. Next word earliest edge M+1.
//  Exactly one write per Request high phase, regardless of Request width.
//  Read: read=1 && !empty at edge N -> dataOut<=mem[rd_ptr], rd_ptr++, dataValid=1 for the
//   cycle after N. read=1 && empty -> no pointer change, dataValid=0, rdErr<=1 (sticky).
//  Pointers: AW bits, wrap DEPTH-1 -> 0 naturally.
//  count: +1 on write only, -1 on read only, unchanged on simultaneous write+read.
//   Simultaneous write+read when empty: read is rejected (rdErr set), write proceeds.
//   Simultaneous write+read when full: write blocked (full sampled), read proceeds.
//  full/empty: combinational from count, valid the same cycle count changes.
//  Memory: one write port, one registered read port; no read-during-write bypass is needed
//   because a read of an empty slot is rejected.
// CONFIGURATION
//  RECEIVER_SYNC_EN defined: Request passes through a 2-flop synchronizer (reset to 0) before
//   the FSM. This adds 2 cycles to the Request->Ack and Request-low->Ack-low latencies.
//   rcvDataIn is still sampled directly; the sender holds it stable while Request=1.
//  Not defined: req = Request directly, with the latencies given above.
// TESTING
//  1. Reset, then one handshake with 16'hA5A5 -> Ack high 1 cycle after Request, low 1 cycle
//     after Request drops. count=1. read -> dataOut=16'hA5A5, dataValid pulses once, empty=1.
//  2. 16 handshakes 16'h0000..16'h000F -> full=1, count=16. 17th Request -> Ack stays 0.
//     One read -> 17th word is then accepted with Ack, and later reads return in order.
//  3. Request held high 10 cycles -> exactly one write, count=1, Ack high until Request drops.
//  4. read on empty -> rdErr=1, remains 1 after later valid traffic until Reset_n=0.
//  5. count=5, handshake and read on the same edge -> count stays 5, FIFO order intact
//     across pointer wrap (40 words streamed with interleaved reads).
//  6. Reset_n low while Ack=1 -> Ack, count and dataValid are 0 at once. With
//     RECEIVER_SYNC_EN defined, repeat test 1 -> Ack rises 3 cycles after Request.

Source files
------------

// File: rtl/receiver_control.sv
// Receive-side four-phase Request/Ack endpoint feeding a DEPTH-entry circular buffer popped by a host read strobe.
// Optional RECEIVER_SYNC_EN: Request passes through a 2-flop synchronizer before the handshake FSM.
module receiver_control #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             Request,
  input  logic [WIDTH-1:0] rcvDataIn,
  output logic             Ack,
  input  logic             read,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             rdErr
);

  typedef enum logic {IDLE, ACK_S} state_t;

  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             req;
  logic             wr_en;
  logic             rd_en;

`ifdef RECEIVER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= Request;
      sync2_q <= sync1_q;
    end
  end

  assign req = sync2_q;
`else
  assign req = Request;
`endif

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  // A read is judged against the count before this edge, so a simultaneous write never rescues an empty read.
  assign rd_en = read && !empty;

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !full) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_S;
        end
      end
      ACK_S: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    err_d    = err_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
      dv_d     = 1'b1;
    end
    if (read && empty) err_d = 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rcvDataIn;
  end

  assign Ack       = ack_q;
  assign dataOut   = dout_q;
  assign dataValid = dv_q;
  assign count     = count_q;
  assign rdErr     = err_q;

endmodule

// File: tb/tb_receiver_control.sv
// Randomized scoreboard bench for receiver_control: a queue-based model predicts handshake outcomes and popped words.
module tb_receiver_control;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef RECEIVER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             Reset_n;
  logic             Request;
  logic [WIDTH-1:0] rcvDataIn;
  logic             Ack;
  logic             read;
  logic [WIDTH-1:0] dataOut;
  logic             dataValid;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             rdErr;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             m_err;

  receiver_control #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .Reset_n(Reset_n), .Request(Request), .rcvDataIn(rcvDataIn),
    .Ack(Ack), .read(read), .dataOut(dataOut), .dataValid(dataValid),
    .count(count), .full(full), .empty(empty), .rdErr(rdErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (Reset_n === 1'b1 && dataValid === 1'b1) begin
      if (exp_q.size() == 0) chk("dv_unexpected", 32'd1, 32'd0);
      else chk("dataOut", {16'h0, dataOut}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_level();
    chk("count", {27'h0, count}, mq.size());
    chk("full", {31'h0, full}, {31'h0, mq.size() == DEPTH});
    chk("empty", {31'h0, empty}, {31'h0, mq.size() == 0});
    chk("rdErr", {31'h0, rdErr}, {31'h0, m_err});
  endtask

  task automatic raise_req(input logic [WIDTH-1:0] d);
    Request   = 1'b1;
    rcvDataIn = d;
    repeat (LAT - 1) begin
      tick();
      chk("ack_early", {31'h0, Ack}, 32'd0);
    end
  endtask

  task automatic drop_req();
    Request = 1'b0;
    repeat (LAT - 1) begin
      tick();
      chk("ack_hold", {31'h0, Ack}, 32'd1);
    end
    tick();
    chk("ack_fall", {31'h0, Ack}, 32'd0);
  endtask

  task automatic do_write(input logic [WIDTH-1:0] d);
    raise_req(d);
    tick();
    chk("ack_rise", {31'h0, Ack}, 32'd1);
    mq.push_back(d);
    chk_level();
    drop_req();
  endtask

  task automatic do_read();
    logic had;
    had  = (mq.size() > 0);
    read = 1'b1;
    if (had) exp_q.push_back(mq.pop_front());
    else m_err = 1'b1;
    tick();
    read = 1'b0;
    chk("dataValid", {31'h0, dataValid}, {31'h0, had});
    chk_level();
  endtask

  task automatic sim_wr_rd(input logic [WIDTH-1:0] d);
    raise_req(d);
    read = 1'b1;
    exp_q.push_back(mq.pop_front());
    mq.push_back(d);
    tick();
    read = 1'b0;
    chk("sim_ack", {31'h0, Ack}, 32'd1);
    chk("sim_dv", {31'h0, dataValid}, 32'd1);
    chk_level();
    drop_req();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Request = 1'b0; read = 1'b0; rcvDataIn = '0; m_err = 1'b0;
    #2;
    chk("rst_ack", {31'h0, Ack}, 32'd0);
    chk("rst_dout", {16'h0, dataOut}, 32'd0);
    chk("rst_dv", {31'h0, dataValid}, 32'd0);
    chk_level();
    @(posedge clk); #1 Reset_n = 1'b1;
    tick();

    // 1: single handshake and read-back
    do_write(16'hA5A5);
    do_read();

    // 2: fill, backpressure on 17th, one read frees a slot
    for (int i = 0; i < DEPTH; i++) do_write(16'(i));
    Request = 1'b1; rcvDataIn = 16'h0010;
    repeat (LAT + 3) begin
      tick();
      chk("ack_bp", {31'h0, Ack}, 32'd0);
      chk_level();
    end
    read = 1'b1;
    exp_q.push_back(mq.pop_front());
    tick();
    read = 1'b0;
    chk("bp_dv", {31'h0, dataValid}, 32'd1);
    chk("bp_ack", {31'h0, Ack}, 32'd0);
    chk_level();
    tick();
    chk("bp_accept", {31'h0, Ack}, 32'd1);
    mq.push_back(16'h0010);
    chk_level();
    drop_req();
    while (mq.size() > 0) do_read();

    // 3: long Request gives a single write
    raise_req(16'h1234);
    tick();
    chk("long_ack", {31'h0, Ack}, 32'd1);
    mq.push_back(16'h1234);
    repeat (9) begin
      tick();
      chk("long_hold", {31'h0, Ack}, 32'd1);
      chk_level();
    end
    drop_req();
    chk_level();
    do_read();

    // 4: read on empty is sticky
    do_read();
    do_write(16'h7777);
    do_read();

    // 5: simultaneous write+read at count 5, then random stream across wrap
    for (int i = 0; i < 5; i++) do_write(16'($urandom));
    sim_wr_rd(16'hC0DE);
    for (int i = 0; i < 40; i++) begin
      int c;
      c = $urandom_range(0, 2);
      if (mq.size() >= DEPTH - 1) do_read();
      if (c == 1 && mq.size() > 0) sim_wr_rd(16'($urandom));
      else begin
        do_write(16'($urandom));
        if (c == 2) do_read();
      end
    end
    while (mq.size() > 0) do_read();

    // 6: reset while Ack and dataValid are high
    do_write(16'hBEEF);
    raise_req(16'hCAFE);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("pre_rst_ack", {31'h0, Ack}, 32'd1);
    chk("pre_rst_dv", {31'h0, dataValid}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    Request = 1'b0;
    mq.delete(); exp_q.delete(); m_err = 1'b0;
    chk("rst_ack", {31'h0, Ack}, 32'd0);
    chk("rst_dv", {31'h0, dataValid}, 32'd0);
    chk("rst_dout", {16'h0, dataOut}, 32'd0);
    chk_level();
    @(posedge clk); #1 Reset_n = 1'b1;
    tick();
    do_write(16'h5A5A);
    do_read();
    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
